// File: rtl/spy_burst_sched.sv
// -----------------------------------------------------------------------------
// spy_burst_sched
//
// Purpose:
//   Round-robin scheduler between two burst requesters and a single burst
//   engine. One command is in flight at a time. Each granted command is checked
//   for word alignment and 4 KB page crossing. Legal commands are issued to the
//   engine and their completion response is forwarded. Illegal commands are
//   answered directly with SLVERR (2'b10).
//
// Configuration:
//   SPY_SCHED_WATCHDOG_EN  When defined, a 16-bit watchdog runs while waiting
//                          for the engine. It expires after WDT_CYCLES cycles,
//                          pulses TIMEOUT and answers with DECERR (2'b11).
//                          When undefined, TIMEOUT is tied to 0.
//
// Parameters:
//   ADDR_WIDTH  command / engine address width (must be >= 12)
//   WDT_CYCLES  watchdog limit in cycles, 2..65535 (used only with the macro)
//
// Ports:
//   ACLK, ARESET                  clock, synchronous active-high reset
//   REQn_VALID/READY              requester n command handshake (READY = 1-cycle grant)
//   REQn_WRITE/ADDR/LEN           requester n command: direction, byte address, AXI LEN
//   ENG_START                     1-cycle issue pulse to the burst engine
//   ENG_WRITE/ADDR/LEN/ID         issued command, held from issue until back in IDLE
//   ENG_DONE, ENG_RESP            engine completion pulse and AXI response code
//   RSP_VALID[1:0], RSP_RESP      one-hot completion pulse per requester and its code
//   TIMEOUT                       watchdog expiry pulse
// -----------------------------------------------------------------------------
module spy_burst_sched #(
   parameter int ADDR_WIDTH = 32,
   parameter int WDT_CYCLES = 256
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  REQ0_VALID,
   output logic                  REQ0_READY,
   input  logic                  REQ0_WRITE,
   input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
   input  logic [7:0]            REQ0_LEN,
   input  logic                  REQ1_VALID,
   output logic                  REQ1_READY,
   input  logic                  REQ1_WRITE,
   input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
   input  logic [7:0]            REQ1_LEN,
   output logic                  ENG_START,
   output logic                  ENG_WRITE,
   output logic [ADDR_WIDTH-1:0] ENG_ADDR,
   output logic [7:0]            ENG_LEN,
   output logic                  ENG_ID,
   input  logic                  ENG_DONE,
   input  logic [1:0]            ENG_RESP,
   output logic [1:0]            RSP_VALID,
   output logic [1:0]            RSP_RESP,
   output logic                  TIMEOUT
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
   logic [7:0]              len_q,   len_d;
   logic                    id_q,    id_d;
   logic [1:0]              code_q,  code_d;
   // Id of the requester served last; the other one wins a tie.
   logic                    last_q,  last_d;

   logic                    any_valid;
   logic                    grant_id;
   logic [12:0]             end_off;
   logic                    illegal;
   logic                    wdt_expire;

   // ---------------------------------------------------------------------------
   // Arbitration and legality
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a value on every path
   // (defaults first or full if/else), otherwise a latch is inferred.
   always_comb begin
      any_valid = REQ0_VALID | REQ1_VALID;
      if (REQ0_VALID && REQ1_VALID) begin
         grant_id = ~last_q;
      end else begin
         grant_id = REQ1_VALID;
      end
   end

   // End offset of the burst within its 4 KB page; 13 bits so the largest
   // case (0xFFF + 1024) cannot wrap. Landing exactly on 4096 is still legal.
   always_comb begin
      end_off = {1'b0, addr_q[11:0]} + {3'b000, len_q, 2'b00} + 13'd4;
      illegal = (addr_q[1:0] != 2'b00) || (end_off > 13'd4096);
   end

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
`ifdef SPY_SCHED_WATCHDOG_EN
   localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);

   logic [15:0] wdt_cnt_q, wdt_cnt_d;

   // Counter is zero in every state but WAIT, so it is cleared on entry.
   // ENG_DONE on the expiry cycle wins over the watchdog.
   always_comb begin
      wdt_cnt_d  = (state_q == S_WAIT) ? (wdt_cnt_q + 16'd1) : 16'd0;
      wdt_expire = (state_q == S_WAIT) && (wdt_cnt_q == WDT_LAST) && !ENG_DONE;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
      end
   end
`else
   assign wdt_expire = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_valid) state_d = S_ISSUE;
         S_ISSUE: state_d = illegal ? S_RESP : S_WAIT;
         S_WAIT:  if (ENG_DONE || wdt_expire) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Command / response datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      write_d = write_q;
      addr_d  = addr_q;
      len_d   = len_q;
      id_d    = id_q;
      code_d  = code_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               id_d    = grant_id;
               write_d = grant_id ? REQ1_WRITE : REQ0_WRITE;
               addr_d  = grant_id ? REQ1_ADDR  : REQ0_ADDR;
               len_d   = grant_id ? REQ1_LEN   : REQ0_LEN;
               code_d  = 2'b00;
            end
         end
         S_ISSUE: begin
            if (illegal) code_d = 2'b10;
         end
         S_WAIT: begin
            if (ENG_DONE) begin
               code_d = ENG_RESP;
            end else if (wdt_expire) begin
               code_d = 2'b11;
            end
         end
         S_RESP: begin
            last_d = id_q;
         end
         default: ;
      endcase
   end

   // Reset makes requester 1 look like the last one served, so requester 0
   // wins the first tie.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         id_q    <= 1'b0;
         code_q  <= 2'b00;
         last_q  <= 1'b1;
      end else begin
         write_q <= write_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         id_q    <= id_d;
         code_q  <= code_d;
         last_q  <= last_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   // Outputs are forced low while ARESET is high, including the grant, which
   // would otherwise follow REQn_VALID combinationally in IDLE.
   always_comb begin
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      ENG_START  = 1'b0;
      ENG_WRITE  = 1'b0;
      ENG_ADDR   = '0;
      ENG_LEN    = '0;
      ENG_ID     = 1'b0;
      RSP_VALID  = 2'b00;
      RSP_RESP   = 2'b00;
      TIMEOUT    = 1'b0;
      if (!ARESET) begin
         case (state_q)
            S_IDLE: begin
               REQ0_READY = any_valid && !grant_id;
               REQ1_READY = any_valid &&  grant_id;
            end
            S_ISSUE: begin
               ENG_START = !illegal;
            end
            S_WAIT: ;
            S_RESP: begin
               RSP_VALID = id_q ? 2'b10 : 2'b01;
               RSP_RESP  = code_q;
            end
            default: ;
         endcase
         if (state_q != S_IDLE) begin
            ENG_WRITE = write_q;
            ENG_ADDR  = addr_q;
            ENG_LEN   = len_q;
            ENG_ID    = id_q;
         end
         TIMEOUT = wdt_expire;
      end
   end

endmodule

// File: tb/tb_spy_burst_sched.sv
// -----------------------------------------------------------------------------
// tb_spy_burst_sched
//
// Self-checking bench for spy_burst_sched (ADDR_WIDTH=32, WDT_CYCLES=16).
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge. A per-cycle vector table covers the directed
// cases, hand-written sequences cover contention, reset in WAIT and the
// watchdog, and a transaction-level model checks randomized commands.
// -----------------------------------------------------------------------------
module tb_spy_burst_sched;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic        req0_write = 1'b0, req1_write = 1'b0;
   logic [31:0] req0_addr = '0, req1_addr = '0;
   logic [7:0]  req0_len = '0, req1_len = '0;
   logic        eng_start, eng_write, eng_id;
   logic [31:0] eng_addr;
   logic [7:0]  eng_len;
   logic        eng_done = 1'b0;
   logic [1:0]  eng_resp = 2'b00;
   logic [1:0]  rsp_valid, rsp_resp;
   logic        timeout;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   spy_burst_sched #(.ADDR_WIDTH(32), .WDT_CYCLES(16)) dut (
      .ACLK       (clk),
      .ARESET     (areset),
      .REQ0_VALID (req0_valid),
      .REQ0_READY (req0_ready),
      .REQ0_WRITE (req0_write),
      .REQ0_ADDR  (req0_addr),
      .REQ0_LEN   (req0_len),
      .REQ1_VALID (req1_valid),
      .REQ1_READY (req1_ready),
      .REQ1_WRITE (req1_write),
      .REQ1_ADDR  (req1_addr),
      .REQ1_LEN   (req1_len),
      .ENG_START  (eng_start),
      .ENG_WRITE  (eng_write),
      .ENG_ADDR   (eng_addr),
      .ENG_LEN    (eng_len),
      .ENG_ID     (eng_id),
      .ENG_DONE   (eng_done),
      .ENG_RESP   (eng_resp),
      .RSP_VALID  (rsp_valid),
      .RSP_RESP   (rsp_resp),
      .TIMEOUT    (timeout)
   );

   typedef struct {
      logic        v0, v1, wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic        done;
      logic [1:0]  eresp;
      logic [1:0]  e_rdy;    // {ready1, ready0}
      logic        e_start;
      logic        e_id;
      logic [1:0]  e_rspv;
      logic [1:0]  e_rspr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [49:0] all_outs();
      return {req0_ready, req1_ready, eng_start, eng_write, eng_addr, eng_len,
              eng_id, rsp_valid, rsp_resp, timeout};
   endfunction

   function automatic vec_t mk(logic v0, logic v1, logic wr, logic [31:0] addr,
                               logic [7:0] len, logic done, logic [1:0] eresp,
                               logic [1:0] e_rdy, logic e_start, logic e_id,
                               logic [1:0] e_rspv, logic [1:0] e_rspr);
      vec_t v;
      v.v0 = v0; v.v1 = v1; v.wr = wr; v.addr = addr; v.len = len;
      v.done = done; v.eresp = eresp; v.e_rdy = e_rdy; v.e_start = e_start;
      v.e_id = e_id; v.e_rspv = e_rspv; v.e_rspr = e_rspr;
      return v;
   endfunction

   task automatic set_both(input logic v0, input logic v1, input logic wr,
                           input logic [31:0] addr, input logic [7:0] len);
      req0_valid = v0;  req1_valid = v1;
      req0_write = wr;  req1_write = wr;
      req0_addr  = addr; req1_addr = addr;
      req0_len   = len;  req1_len  = len;
   endtask

   // Reset with both requesters valid: every output must stay low.
   task automatic do_reset();
      @(negedge clk);
      areset = 1'b1;
      set_both(1'b1, 1'b1, 1'b1, 32'h0000_0100, 8'd3);
      eng_done = 1'b1;
      #1 check("reset_outs_a", 64'(all_outs()), 64'd0);
      @(negedge clk);
      #1 check("reset_outs_b", 64'(all_outs()), 64'd0);
      @(negedge clk);
      areset = 1'b0;
      set_both(1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
      eng_done = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table (one row per cycle, starting in IDLE after reset)
   // ---------------------------------------------------------------------------
   task automatic run_table();
      // A: single write, req0, addr 0, LEN 7; DONE in IDLE is ignored
      vecs.push_back(mk(1,0,1,32'h000,8'd7,0,2'b00, 2'b01,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,1,32'h000,8'd7,0,2'b00, 2'b00,1,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,1,32'h000,8'd7,0,2'b00, 2'b00,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,1,32'h000,8'd7,1,2'b00, 2'b00,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,1,32'h000,8'd7,0,2'b00, 2'b00,0,0,2'b01,2'b00));
      vecs.push_back(mk(0,0,1,32'h000,8'd7,1,2'b11, 2'b00,0,0,2'b00,2'b00));
      // B: req1, 0xFE0 LEN 8 crosses 4 KB -> SLVERR at t+2, no start
      vecs.push_back(mk(0,1,0,32'hFE0,8'd8,0,2'b00, 2'b10,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,0,32'hFE0,8'd8,0,2'b00, 2'b00,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,0,32'hFE0,8'd8,0,2'b00, 2'b00,0,0,2'b10,2'b10));
      vecs.push_back(mk(0,0,0,32'hFE0,8'd8,0,2'b00, 2'b00,0,0,2'b00,2'b00));
      // C: req0, 0xFE0 LEN 7 is legal; DONE during ISSUE is ignored
      vecs.push_back(mk(1,0,0,32'hFE0,8'd7,0,2'b00, 2'b01,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,0,32'hFE0,8'd7,1,2'b11, 2'b00,1,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,0,32'hFE0,8'd7,0,2'b00, 2'b00,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,0,32'hFE0,8'd7,1,2'b01, 2'b00,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,0,32'hFE0,8'd7,0,2'b00, 2'b00,0,0,2'b01,2'b01));
      // D: both valid, last served was 0 -> req1; addr 0x2 unaligned
      vecs.push_back(mk(1,1,1,32'h002,8'd0,0,2'b00, 2'b10,0,0,2'b00,2'b00));
      vecs.push_back(mk(1,1,1,32'h002,8'd0,0,2'b00, 2'b00,0,0,2'b00,2'b00));
      vecs.push_back(mk(1,1,1,32'h002,8'd0,0,2'b00, 2'b00,0,0,2'b10,2'b10));
      // E: both valid, last served was 1 -> req0; 0xFFC LEN 0 ends exactly on 4 KB
      vecs.push_back(mk(1,1,1,32'hFFC,8'd0,0,2'b00, 2'b01,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,1,32'hFFC,8'd0,0,2'b00, 2'b00,1,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,1,32'hFFC,8'd0,1,2'b10, 2'b00,0,0,2'b00,2'b00));
      vecs.push_back(mk(0,0,1,32'hFFC,8'd0,0,2'b00, 2'b00,0,0,2'b01,2'b10));
      vecs.push_back(mk(0,0,1,32'hFFC,8'd0,0,2'b00, 2'b00,0,0,2'b00,2'b00));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         set_both(vecs[i].v0, vecs[i].v1, vecs[i].wr, vecs[i].addr, vecs[i].len);
         eng_done = vecs[i].done;
         eng_resp = vecs[i].eresp;
         #1;
         check($sformatf("tbl%0d_ready", i), {req1_ready, req0_ready}, vecs[i].e_rdy);
         check($sformatf("tbl%0d_start", i), eng_start, vecs[i].e_start);
         if (vecs[i].e_start) begin
            check($sformatf("tbl%0d_id", i),    eng_id,    vecs[i].e_id);
            check($sformatf("tbl%0d_addr", i),  eng_addr,  vecs[i].addr);
            check($sformatf("tbl%0d_len", i),   eng_len,   vecs[i].len);
            check($sformatf("tbl%0d_write", i), eng_write, vecs[i].wr);
         end
         check($sformatf("tbl%0d_rspv", i), rsp_valid, vecs[i].e_rspv);
         check($sformatf("tbl%0d_rspr", i), rsp_resp,  vecs[i].e_rspr);
         check($sformatf("tbl%0d_tmo", i),  timeout,   1'b0);
      end
      eng_done = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Contention from reset, then reset while in WAIT
   // ---------------------------------------------------------------------------
   task automatic run_contention_and_reset();
      int   grants[$];
      int   exp_order[4] = '{0, 1, 0, 1};
      logic done_next = 1'b0;

      do_reset();
      for (int c = 0; c < 200 && grants.size() < 4; c++) begin
         @(negedge clk);
         set_both(1'b1, 1'b1, 1'b0, 32'h0000_0100, 8'd3);
         eng_done = done_next;
         eng_resp = 2'b00;
         #1;
         done_next = eng_start;
         if (req0_ready) grants.push_back(0);
         if (req1_ready) grants.push_back(1);
      end
      check("contention_count", grants.size(), 4);
      for (int i = 0; i < grants.size() && i < 4; i++)
         check($sformatf("contention_grant%0d", i), grants[i], exp_order[i]);

      // The 4th command (req1) goes to ISSUE, then WAIT, where reset hits.
      @(negedge clk);
      set_both(1'b0, 1'b0, 1'b0, 32'h0000_0100, 8'd3);
      eng_done = 1'b0;
      #1;
      check("rst_issue_start", eng_start, 1'b1);
      check("rst_issue_id", eng_id, 1'b1);
      @(negedge clk);
      areset = 1'b1;
      #1 check("rst_in_wait_outs", 64'(all_outs()), 64'd0);
      @(negedge clk);
      areset = 1'b0;
      #1 check("rst_next_cycle_outs", 64'(all_outs()), 64'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         eng_done = 1'b1;
         #1 check("rst_no_rsp", rsp_valid, 2'b00);
      end
      @(negedge clk);
      eng_done = 1'b0;
      set_both(1'b1, 1'b1, 1'b1, 32'h0000_0200, 8'd1);
      #1 check("rst_next_grant", {req1_ready, req0_ready}, 2'b01);
      @(negedge clk);
      set_both(1'b0, 1'b0, 1'b1, 32'h0000_0200, 8'd1);
      #1 check("rst_after_start", eng_start, 1'b1);
      @(negedge clk);
      eng_done = 1'b1;
      eng_resp = 2'b01;
      #1;
      @(negedge clk);
      eng_done = 1'b0;
      #1;
      check("rst_after_rspv", rsp_valid, 2'b01);
      check("rst_after_rspr", rsp_resp, 2'b01);
      @(negedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog: grant at k=0, then k=1..45 with DONE driven in [dlo, dhi]
   // ---------------------------------------------------------------------------
   task automatic wdt_run(input string tag, input int dlo, input int dhi, input logic [1:0] eresp,
                          input int exp_to_cnt, input int exp_to_first,
                          input int exp_rsp_first, input logic [1:0] exp_code);
      int         to_cnt = 0, to_first = -1, rsp_cnt = 0, rsp_first = -1;
      logic [1:0] code = 2'b00, rspv = 2'b00;

      @(negedge clk);
      set_both(1'b1, 1'b0, 1'b1, 32'h0000_0040, 8'd3);
      #1 check({tag, "_grant"}, {req1_ready, req0_ready}, 2'b01);
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         set_both(1'b0, 1'b0, 1'b1, 32'h0000_0040, 8'd3);
         eng_done = (k >= dlo) && (k <= dhi);
         eng_resp = eresp;
         #1;
         if (timeout) begin
            to_cnt++;
            if (to_first < 0) to_first = k;
         end
         if (rsp_valid != 2'b00) begin
            rsp_cnt++;
            if (rsp_first < 0) begin
               rsp_first = k;
               code = rsp_resp;
               rspv = rsp_valid;
            end
         end
      end
      eng_done = 1'b0;
      check({tag, "_timeout_pulses"}, to_cnt, exp_to_cnt);
      if (exp_to_cnt > 0) check({tag, "_timeout_cycle"}, to_first, exp_to_first);
      check({tag, "_rsp_pulses"}, rsp_cnt, 1);
      check({tag, "_rsp_cycle"}, rsp_first, exp_rsp_first);
      check({tag, "_rsp_valid"}, rspv, 2'b01);
      check({tag, "_rsp_code"}, code, exp_code);
   endtask

   // ---------------------------------------------------------------------------
   // Randomized commands against a transaction-level model
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] rand_addr();
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) a[11:8] = 4'hF;
      return a;
   endfunction

   function automatic logic [7:0] rand_len();
      return 8'($urandom_range(0, 1) == 1 ? $urandom_range(0, 15) : $urandom_range(0, 255));
   endfunction

   task automatic run_random(input int n_tx);
      int last_win = 1;   // after reset requester 0 wins the first tie
      do_reset();
      for (int t = 0; t < n_tx; t++) begin
         int          sel   = $urandom_range(1, 3);
         logic        v0    = sel[0];
         logic        v1    = sel[1];
         logic [31:0] a0    = rand_addr();
         logic [31:0] a1    = rand_addr();
         logic [7:0]  l0    = rand_len();
         logic [7:0]  l1    = rand_len();
         logic        w0    = 1'($urandom_range(0, 1));
         logic        w1    = 1'($urandom_range(0, 1));
         int          win;
         logic [31:0] wa;
         logic [7:0]  wl;
         logic        ww;
         bit          legal;
         int          delay;
         logic [1:0]  er;

         win   = (v0 && v1) ? (1 - last_win) : (v1 ? 1 : 0);
         wa    = win ? a1 : a0;
         wl    = win ? l1 : l0;
         ww    = win ? w1 : w0;
         legal = (wa % 4 == 0) && ((wa % 4096) + 4 * (int'(wl) + 1) <= 4096);

         // Grant cycle
         @(negedge clk);
         req0_valid = v0; req0_addr = a0; req0_len = l0; req0_write = w0;
         req1_valid = v1; req1_addr = a1; req1_len = l1; req1_write = w1;
         eng_done = 1'b0;
         #1;
         check("rnd_ready", {req1_ready, req0_ready}, win ? 2'b10 : 2'b01);
         check("rnd_idle_rspv", rsp_valid, 2'b00);

         // Issue cycle (requests stay valid; READY must stay low)
         @(negedge clk);
         #1;
         check("rnd_busy_ready", {req1_ready, req0_ready}, 2'b00);
         check("rnd_start", eng_start, legal);
         if (legal) begin
            check("rnd_eng_addr", eng_addr, wa);
            check("rnd_eng_len", eng_len, wl);
            check("rnd_eng_write", eng_write, ww);
            check("rnd_eng_id", eng_id, win);
            delay = $urandom_range(0, 10);
            for (int d = 0; d < delay; d++) begin
               @(negedge clk);
               #1 check("rnd_wait_rspv", rsp_valid, 2'b00);
            end
            er = 2'($urandom_range(0, 3));
            @(negedge clk);
            eng_done = 1'b1;
            eng_resp = er;
            #1 check("rnd_done_rspv", rsp_valid, 2'b00);
            @(negedge clk);
            eng_done = 1'b0;
            #1;
            check("rnd_hold_addr", eng_addr, wa);
         end else begin
            er = 2'b10;
            @(negedge clk);
            #1;
         end
         check("rnd_rspv", rsp_valid, win ? 2'b10 : 2'b01);
         check("rnd_rspr", rsp_resp, er);
         check("rnd_tmo", timeout, 1'b0);
         last_win = win;

         req0_valid = 1'b0;
         req1_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            #1 check("rnd_gap_ready", {req1_ready, req0_ready}, 2'b00);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      do_reset();
      run_table();
      run_contention_and_reset();
`ifdef SPY_SCHED_WATCHDOG_EN
      // No DONE before expiry: TIMEOUT on the 16th WAIT cycle (k=17), DECERR at
      // k=18; DONE pulses arriving afterwards are ignored.
      wdt_run("wdt_expire", 18, 20, 2'b00, 1, 17, 18, 2'b11);
      // DONE on the expiry cycle wins: no TIMEOUT, normal response.
      wdt_run("wdt_done_wins", 17, 17, 2'b01, 0, 0, 18, 2'b01);
`else
      // No watchdog: waits past the limit silently, answers only on DONE.
      wdt_run("wdt_off", 41, 41, 2'b01, 0, 0, 42, 2'b01);
`endif
      run_random(150);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL global_timeout: simulation did not complete, got no finish, expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
